// File: rtl/nrisc_pkg.sv
// Shared types and encodings for the call/return sequencer and its depth counter.
package nrisc_pkg;

  localparam int unsigned TAM_DEF    = 16;
  localparam int unsigned NSTACK_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PUSH,
    ST_POP,
    ST_SETTLE,
    ST_FAULT
  } state_t;

  // Request picked in IDLE after priority resolution
  typedef enum logic [2:0] {
    REQ_NONE,
    REQ_IRQ,
    REQ_CALL,
    REQ_RETI,
    REQ_RET
  } req_t;

  localparam logic [1:0] FLT_NONE = 2'b00;
  localparam logic [1:0] FLT_OVF  = 2'b01;
  localparam logic [1:0] FLT_UDF  = 2'b10;

  localparam logic [1:0] STK_IDLE = 2'b00;
  localparam logic [1:0] STK_PUSH = 2'b01;
  localparam logic [1:0] STK_POP  = 2'b10;

endpackage

// File: rtl/stack_depth_cnt.sv
// Up/down counter tracking live return-stack entries; saturates at 0 and NStack.
module stack_depth_cnt
  import nrisc_pkg::*;
#(
  parameter int unsigned NStack = NSTACK_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_inc,
  input  logic                          i_dec,
  output logic [$clog2(NStack+1)-1:0]   o_depth,
  output logic                          o_full,
  output logic                          o_empty
);

  localparam int unsigned DW = $clog2(NStack + 1);

  logic [DW-1:0] r_depth;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_depth <= '0;
    end else if (i_inc && !i_dec && !o_full) begin
      r_depth <= r_depth + DW'(1);
    end else if (i_dec && !i_inc && !o_empty) begin
      r_depth <= r_depth - DW'(1);
    end
  end

  assign o_depth = r_depth;
  assign o_full  = (r_depth == DW'(NStack));
  assign o_empty = (r_depth == '0);

endmodule

// File: rtl/call_ret_seq.sv
// Sequences CALL/RET/RETI/IRQ into push/pop edges for the PC/flags return stack
// and drives the PC/flags reload; halts in FAULT on stack overflow/underflow.
module call_ret_seq
  import nrisc_pkg::*;
#(
  parameter int unsigned     TAM       = TAM_DEF,
  parameter int unsigned     NStack    = NSTACK_DEF,
  parameter logic [TAM-1:0]  IRQ_VEC   = TAM'(16'h0004),
  parameter logic [TAM-1:0]  FAULT_VEC = TAM'(16'h0002)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          call_req,
  input  logic                          ret_req,
  input  logic                          reti_req,
  input  logic                          irq_req,
  input  logic [TAM-1:0]                call_target,
  input  logic [TAM-1:0]                pc_ret,
  input  logic [2:0]                    flags_cur,
  input  logic [TAM-1:0]                stk_pc,
  input  logic [2:0]                    stk_flags,
  output logic [1:0]                    stk_ctrl,
  output logic [TAM-1:0]                stk_pc_in,
  output logic [2:0]                    stk_flags_in,
  output logic                          pc_load,
  output logic [TAM-1:0]                pc_next,
  output logic                          flags_load,
  output logic [2:0]                    flags_next,
  output logic                          busy,
  output logic                          irq_ack,
  output logic                          ie,
  output logic [$clog2(NStack+1)-1:0]   depth,
  output logic [1:0]                    fault
);

  state_t         r_state, w_state_nxt;
  req_t           w_req;
  logic           w_full, w_empty;

  logic [1:0]     r_stk_ctrl,     w_stk_ctrl_d;
  logic [TAM-1:0] r_stk_pc_in,    w_stk_pc_in_d;
  logic [2:0]     r_stk_flags_in, w_stk_flags_in_d;
  logic           r_pc_load,      w_pc_load_d;
  logic [TAM-1:0] r_pc_next,      w_pc_next_d;
  logic           r_flags_load,   w_flags_load_d;
  logic [2:0]     r_flags_next,   w_flags_next_d;
  logic           r_busy,         w_busy_d;
  logic           r_irq_ack,      w_irq_ack_d;
  logic           r_ie,           w_ie_d;
  logic [1:0]     r_fault,        w_fault_d;
  logic [TAM-1:0] r_target,       w_target_d;
  logic [2:0]     r_tflags,       w_tflags_d;
  logic           r_reti,         w_reti_d;

  stack_depth_cnt #(.NStack(NStack)) u_depth (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (r_state == ST_PUSH),
    .i_dec   (r_state == ST_POP),
    .o_depth (depth),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next state; requests are only looked at in IDLE, highest priority wins
  always_comb begin
    w_state_nxt = r_state;
    w_req       = REQ_NONE;
    case (r_state)
      ST_IDLE: begin
        if (irq_req && r_ie) w_req = REQ_IRQ;
        else if (call_req)   w_req = REQ_CALL;
        else if (reti_req)   w_req = REQ_RETI;
        else if (ret_req)    w_req = REQ_RET;
        case (w_req)
          REQ_IRQ, REQ_CALL: w_state_nxt = w_full  ? ST_FAULT : ST_PUSH;
          REQ_RETI, REQ_RET: w_state_nxt = w_empty ? ST_FAULT : ST_POP;
          default:           w_state_nxt = ST_IDLE;
        endcase
      end
      ST_PUSH, ST_POP: w_state_nxt = ST_SETTLE;
      ST_SETTLE:       w_state_nxt = ST_IDLE;
      default:         w_state_nxt = ST_FAULT;
    endcase
  end

  // Output next-values, keyed on the state being entered so outputs can be registered
  always_comb begin
    w_stk_ctrl_d     = STK_IDLE;
    w_pc_load_d      = 1'b0;
    w_flags_load_d   = 1'b0;
    w_irq_ack_d      = 1'b0;
    w_stk_pc_in_d    = r_stk_pc_in;
    w_stk_flags_in_d = r_stk_flags_in;
    w_pc_next_d      = r_pc_next;
    w_flags_next_d   = r_flags_next;
    w_target_d       = r_target;
    w_tflags_d       = r_tflags;
    w_reti_d         = r_reti;
    w_ie_d           = r_ie;
    w_fault_d        = r_fault;
    w_busy_d         = (w_state_nxt != ST_IDLE);
    case (w_state_nxt)
      ST_PUSH: begin
        w_stk_ctrl_d     = STK_PUSH;
        w_stk_pc_in_d    = pc_ret;
        w_stk_flags_in_d = flags_cur;
        w_target_d       = (w_req == REQ_IRQ) ? IRQ_VEC : call_target;
        w_reti_d         = 1'b0;
        if (w_req == REQ_IRQ) begin
          w_irq_ack_d = 1'b1;
          w_ie_d      = 1'b0;
        end
      end
      ST_POP: begin
        w_stk_ctrl_d = STK_POP;
        w_target_d   = stk_pc;
        w_tflags_d   = stk_flags;
        w_reti_d     = (w_req == REQ_RETI);
      end
      ST_SETTLE: begin
        w_pc_load_d = 1'b1;
        w_pc_next_d = r_target;
        if (r_reti) begin
          w_flags_load_d = 1'b1;
          w_flags_next_d = r_tflags;
          w_ie_d         = 1'b1;
        end
      end
      ST_FAULT: begin
        if (r_state == ST_IDLE) begin
          w_pc_load_d = 1'b1;
          w_pc_next_d = FAULT_VEC;
          w_fault_d   = ((w_req == REQ_RET) || (w_req == REQ_RETI)) ? FLT_UDF : FLT_OVF;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stk_ctrl     <= STK_IDLE;
      r_stk_pc_in    <= '0;
      r_stk_flags_in <= '0;
      r_pc_load      <= 1'b0;
      r_pc_next      <= '0;
      r_flags_load   <= 1'b0;
      r_flags_next   <= '0;
      r_busy         <= 1'b0;
      r_irq_ack      <= 1'b0;
      r_ie           <= 1'b1;
      r_fault        <= FLT_NONE;
      r_target       <= '0;
      r_tflags       <= '0;
      r_reti         <= 1'b0;
    end else begin
      r_stk_ctrl     <= w_stk_ctrl_d;
      r_stk_pc_in    <= w_stk_pc_in_d;
      r_stk_flags_in <= w_stk_flags_in_d;
      r_pc_load      <= w_pc_load_d;
      r_pc_next      <= w_pc_next_d;
      r_flags_load   <= w_flags_load_d;
      r_flags_next   <= w_flags_next_d;
      r_busy         <= w_busy_d;
      r_irq_ack      <= w_irq_ack_d;
      r_ie           <= w_ie_d;
      r_fault        <= w_fault_d;
      r_target       <= w_target_d;
      r_tflags       <= w_tflags_d;
      r_reti         <= w_reti_d;
    end
  end

  assign stk_ctrl     = r_stk_ctrl;
  assign stk_pc_in    = r_stk_pc_in;
  assign stk_flags_in = r_stk_flags_in;
  assign pc_load      = r_pc_load;
  assign pc_next      = r_pc_next;
  assign flags_load   = r_flags_load;
  assign flags_next   = r_flags_next;
  assign busy         = r_busy;
  assign irq_ack      = r_irq_ack;
  assign ie           = r_ie;
  assign fault        = r_fault;

endmodule

// File: tb/tb_call_ret_seq.sv
// Self-checking bench for call_ret_seq: transaction-level timeline model plus directed cases.
module tb_call_ret_seq;

  localparam int NST  = 8;
  localparam int NCYC = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        call_req = 1'b0, ret_req = 1'b0, reti_req = 1'b0, irq_req = 1'b0;
  logic [15:0] call_target = '0, pc_ret = '0, stk_pc = '0;
  logic [2:0]  flags_cur = '0, stk_flags = '0;
  logic [1:0]  stk_ctrl;
  logic [15:0] stk_pc_in, pc_next;
  logic [2:0]  stk_flags_in, flags_next;
  logic        pc_load, flags_load, busy, irq_ack, ie;
  logic [3:0]  depth;
  logic [1:0]  fault;

  call_ret_seq #(.TAM(16), .NStack(NST), .IRQ_VEC(16'h0004), .FAULT_VEC(16'h0002)) dut (
    .clk(clk), .rst(rst), .call_req(call_req), .ret_req(ret_req), .reti_req(reti_req),
    .irq_req(irq_req), .call_target(call_target), .pc_ret(pc_ret), .flags_cur(flags_cur),
    .stk_pc(stk_pc), .stk_flags(stk_flags), .stk_ctrl(stk_ctrl), .stk_pc_in(stk_pc_in),
    .stk_flags_in(stk_flags_in), .pc_load(pc_load), .pc_next(pc_next),
    .flags_load(flags_load), .flags_next(flags_next), .busy(busy), .irq_ack(irq_ack),
    .ie(ie), .depth(depth), .fault(fault)
  );

  always #5 clk = ~clk;

  // Expected events per cycle: strobes for that cycle plus level changes starting there
  typedef struct {
    bit push, pop, pcl, fll, ack;
    logic [15:0] pcn, spi;
    logic [2:0]  fln, sfi;
    bit dv;  int d;
    bit iev; bit ie;
    bit fv;  logic [1:0] f;
    bit bv;  bit b;
  } ev_t;

  typedef struct packed { logic [15:0] pc; logic [2:0] fl; } fr_t;

  ev_t tl [NCYC];
  int  cyc = 0;
  int  errs = 0, checks = 0;
  bit  chk_en = 1'b0;

  fr_t m_stk [$];
  fr_t env [$];
  bit  m_ie = 1'b1, m_fault = 1'b0;
  int  m_free = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Environment return stack: acts on the DUT's push/pop edges and presents the top
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) env.delete();
      else if (stk_ctrl == 2'b01) env.push_back('{pc: stk_pc_in, fl: stk_flags_in});
      else if (stk_ctrl == 2'b10 && env.size() > 0) void'(env.pop_back());
      stk_pc    = (env.size() > 0) ? env[env.size()-1].pc : 16'h0;
      stk_flags = (env.size() > 0) ? env[env.size()-1].fl : 3'h0;
    end
  end

  // Per-cycle compare against the timeline model
  initial begin
    int cur_d;
    bit cur_ie, cur_b;
    logic [1:0] cur_f;
    cur_d = 0; cur_ie = 1'b1; cur_b = 1'b0; cur_f = 2'b00;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        if (tl[cyc].dv)  cur_d  = tl[cyc].d;
        if (tl[cyc].iev) cur_ie = tl[cyc].ie;
        if (tl[cyc].fv)  cur_f  = tl[cyc].f;
        if (tl[cyc].bv)  cur_b  = tl[cyc].b;
        chk("stk_ctrl",   32'(stk_ctrl),   32'({tl[cyc].pop, tl[cyc].push}));
        chk("pc_load",    32'(pc_load),    32'(tl[cyc].pcl));
        chk("flags_load", 32'(flags_load), 32'(tl[cyc].fll));
        chk("irq_ack",    32'(irq_ack),    32'(tl[cyc].ack));
        chk("busy",       32'(busy),       32'(cur_b));
        chk("ie",         32'(ie),         32'(cur_ie));
        chk("depth",      32'(depth),      32'(cur_d));
        chk("fault",      32'(fault),      32'(cur_f));
        if (tl[cyc].push) begin
          chk("stk_pc_in",    32'(stk_pc_in),    32'(tl[cyc].spi));
          chk("stk_flags_in", 32'(stk_flags_in), 32'(tl[cyc].sfi));
        end
        if (tl[cyc].pcl) chk("pc_next",    32'(pc_next),    32'(tl[cyc].pcn));
        if (tl[cyc].fll) chk("flags_next", 32'(flags_next), 32'(tl[cyc].fln));
      end
    end
  end

  task automatic fault_ev(int n, logic [1:0] code);
    tl[n+1].pcl = 1'b1; tl[n+1].pcn = 16'h0002;
    tl[n+1].fv  = 1'b1; tl[n+1].f   = code;
    tl[n+1].bv  = 1'b1; tl[n+1].b   = 1'b1;
    m_fault = 1'b1;
  endtask

  // Inputs presented in cycle n are sampled at the end of n; schedule what follows
  task automatic model_accept(bit c, bit r, bit ri, bit iq,
                              logic [15:0] tgt, logic [15:0] pcr, logic [2:0] fl);
    int  n;
    bit  is_irq;
    fr_t top;
    n = cyc;
    if (m_fault || n < m_free || !rst) return;
    is_irq = iq && m_ie;
    if (is_irq || c) begin
      if (m_stk.size() == NST) begin
        fault_ev(n, 2'b01);
      end else begin
        tl[n+1].push = 1'b1; tl[n+1].spi = pcr; tl[n+1].sfi = fl;
        tl[n+1].bv = 1'b1;   tl[n+1].b = 1'b1;
        if (is_irq) begin
          tl[n+1].ack = 1'b1; tl[n+1].iev = 1'b1; tl[n+1].ie = 1'b0;
          m_ie = 1'b0;
        end
        m_stk.push_back('{pc: pcr, fl: fl});
        tl[n+2].pcl = 1'b1; tl[n+2].pcn = is_irq ? 16'h0004 : tgt;
        tl[n+2].dv = 1'b1;  tl[n+2].d = m_stk.size();
        tl[n+3].bv = 1'b1;  tl[n+3].b = 1'b0;
        m_free = n + 3;
      end
    end else if (ri || r) begin
      if (m_stk.size() == 0) begin
        fault_ev(n, 2'b10);
      end else begin
        top = m_stk.pop_back();
        tl[n+1].pop = 1'b1; tl[n+1].bv = 1'b1; tl[n+1].b = 1'b1;
        tl[n+2].pcl = 1'b1; tl[n+2].pcn = top.pc;
        tl[n+2].dv = 1'b1;  tl[n+2].d = m_stk.size();
        if (ri) begin
          tl[n+2].fll = 1'b1; tl[n+2].fln = top.fl;
          tl[n+2].iev = 1'b1; tl[n+2].ie = 1'b1;
          m_ie = 1'b1;
        end
        tl[n+3].bv = 1'b1;  tl[n+3].b = 1'b0;
        m_free = n + 3;
      end
    end
  endtask

  task automatic model_reset();
    for (int k = cyc + 1; k < NCYC; k++) tl[k] = '{default: 0};
    if (cyc + 1 < NCYC) begin
      tl[cyc+1].dv = 1'b1;  tl[cyc+1].d = 0;
      tl[cyc+1].iev = 1'b1; tl[cyc+1].ie = 1'b1;
      tl[cyc+1].fv = 1'b1;  tl[cyc+1].f = 2'b00;
      tl[cyc+1].bv = 1'b1;  tl[cyc+1].b = 1'b0;
    end
    m_stk.delete();
    m_ie = 1'b1; m_fault = 1'b0; m_free = 0;
  endtask

  task automatic drive(bit c, bit r, bit ri, bit iq,
                       logic [15:0] tgt, logic [15:0] pcr, logic [2:0] fl);
    @(negedge clk);
    call_req = c; ret_req = r; reti_req = ri; irq_req = iq;
    call_target = tgt; pc_ret = pcr; flags_cur = fl;
    model_accept(c, r, ri, iq, tgt, pcr, fl);
  endtask

  task automatic idle(int k);
    repeat (k) drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 3'h0);
  endtask

  // Called right after a negedge; reset lands mid-cycle, away from both edges
  task automatic do_reset();
    call_req = 1'b0; ret_req = 1'b0; reti_req = 1'b0; irq_req = 1'b0;
    #2 rst = 1'b0;
    model_reset();
    chk_en = 1'b1;
    #1;
    chk("rst_stk_ctrl", 32'(stk_ctrl), 32'(2'b00));
    chk("rst_busy",     32'(busy),     32'(1'b0));
    chk("rst_depth",    32'(depth),    32'(0));
    chk("rst_fault",    32'(fault),    32'(2'b00));
    chk("rst_ie",       32'(ie),       32'(1'b1));
    chk("rst_pc_load",  32'(pc_load),  32'(1'b0));
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
  endtask

  task automatic rand_step();
    bit c, r, ri, iq;
    c  = ($urandom_range(0, 4) == 0);
    r  = ($urandom_range(0, 5) == 0);
    ri = ($urandom_range(0, 7) == 0);
    iq = ($urandom_range(0, 9) == 0);
    if (m_stk.size() >= NST) begin c = 1'b0; iq = 1'b0; end
    if (m_stk.size() == 0)   begin r = 1'b0; ri = 1'b0; end
    drive(c, r, ri, iq, 16'($urandom), 16'($urandom), 3'($urandom));
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // CALL then RET
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0100, 16'h0010, 3'b101);
    idle(1);
    chk("call_ctrl",     32'(stk_ctrl),     32'(2'b01));
    chk("call_pc_in",    32'(stk_pc_in),    32'(16'h0010));
    chk("call_flags_in", 32'(stk_flags_in), 32'(3'b101));
    idle(1);
    chk("call_pc_load",  32'(pc_load),      32'(1'b1));
    chk("call_pc_next",  32'(pc_next),      32'(16'h0100));
    chk("call_depth",    32'(depth),        32'(1));
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 3'h0);
    idle(1);
    chk("ret_ctrl",       32'(stk_ctrl),   32'(2'b10));
    idle(1);
    chk("ret_pc_next",    32'(pc_next),    32'(16'h0010));
    chk("ret_flags_load", 32'(flags_load), 32'(1'b0));
    chk("ret_depth",      32'(depth),      32'(0));

    // IRQ beats CALL; second IRQ ignored; RETI restores
    drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h0200, 16'h0020, 3'b011);
    idle(1);
    chk("irq_ack",     32'(irq_ack), 32'(1'b1));
    chk("irq_ie",      32'(ie),      32'(1'b0));
    idle(1);
    chk("irq_pc_next", 32'(pc_next), 32'(16'h0004));
    chk("irq_depth",   32'(depth),   32'(1));
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0030, 3'b111);
    idle(1);
    chk("irq2_busy", 32'(busy),     32'(1'b0));
    chk("irq2_ctrl", 32'(stk_ctrl), 32'(2'b00));
    drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 3'h0);
    idle(1);
    chk("reti_ctrl", 32'(stk_ctrl), 32'(2'b10));
    idle(1);
    chk("reti_flags_load", 32'(flags_load), 32'(1'b1));
    chk("reti_flags_next", 32'(flags_next), 32'(3'b011));
    chk("reti_pc_next",    32'(pc_next),    32'(16'h0020));
    chk("reti_ie",         32'(ie),         32'(1'b1));

    repeat (1500) rand_step();
    idle(4);

    // Bring the stack to empty with interrupts enabled
    if (m_stk.size() == 0) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0050, 16'h0005, 3'b000);
      idle(2);
    end
    while (m_stk.size() > 1) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 3'h0);
      idle(2);
    end
    drive(1'b0, m_ie, !m_ie, 1'b0, 16'h0, 16'h0, 3'h0);
    idle(2);

    // Reset while the IRQ push edge is high
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0030, 3'b110);
    idle(1);
    chk("pre_rst_ctrl", 32'(stk_ctrl), 32'(2'b01));
    chk("pre_rst_ie",   32'(ie),       32'(1'b0));
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0400, 16'h0040, 3'b010);
    idle(1);
    chk("post_rst_ctrl",    32'(stk_ctrl), 32'(2'b01));
    idle(1);
    chk("post_rst_pc_next", 32'(pc_next),  32'(16'h0400));
    chk("post_rst_depth",   32'(depth),    32'(1));

    // Underflow
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 3'h0);
    idle(2);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 3'h0);
    idle(1);
    chk("udf_fault",   32'(fault),    32'(2'b10));
    chk("udf_ctrl",    32'(stk_ctrl), 32'(2'b00));
    chk("udf_pc_next", 32'(pc_next),  32'(16'h0002));
    idle(3);
    chk("udf_busy",    32'(busy),     32'(1'b1));

    // Overflow: nine CALLs into eight entries
    @(negedge clk);
    do_reset();
    for (int i = 0; i < NST; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 16'(16'h1000 + i), 16'(16'h0100 + i), 3'(i));
      idle(2);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h2000, 16'h0200, 3'b111);
    idle(1);
    chk("ovf_fault",   32'(fault),      32'(2'b01));
    chk("ovf_pc_load", 32'(pc_load),    32'(1'b1));
    chk("ovf_pc_next", 32'(pc_next),    32'(16'h0002));
    chk("ovf_depth",   32'(depth),      32'(8));
    chk("ovf_pushes",  32'(env.size()), 32'(8));
    repeat (5) drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h3000, 16'h0300, 3'b001);
    idle(2);
    chk("ovf_busy",       32'(busy),       32'(1'b1));
    chk("ovf_pushes_end", 32'(env.size()), 32'(8));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
